conv_accum_requant: RTL and testbench
=====================================

CONV_ACCUM_REQUANT -- requirements
Module: conv_accum_requant

Interface
REQ-001 SHALL have parameter OUT_CH, default 18, the number of output channels processed in parallel.
REQ-002 SHALL have parameter PSUM_WIDTH, default 20, the signed partial-sum width per channel from the MAC array.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, the signed accumulator width.
REQ-004 SHALL have parameters BIAS_WIDTH (16, signed), SCALE_WIDTH (16, unsigned), DATA_WIDTH (8, signed output) and CNT_WIDTH (8, counter width).
REQ-005 SHALL have ports, as follows; one clock; reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_load  in  1  start pulse; accepted only in IDLE
- cfg_acc_num  in  CNT_WIDTH  beats accumulated per output pixel
- cfg_pix_num  in  CNT_WIDTH  output pixels per run
- cfg_shift  in  5  right shift after scaling
- cfg_relu_en  in  1  ReLU enable
- bias_in  in  OUT_CH*BIAS_WIDTH  per-channel bias
- scale_in  in  SCALE_WIDTH  common scale
- psum_in  in  OUT_CH*PSUM_WIDTH  partial sums; channel 0 in the LSBs
- psum_valid_in  in  1  beat valid
- psum_ready_out  out  1  beat accepted when both valid and ready are high
- data_out  out  OUT_CH*DATA_WIDTH  requantised pixel
- data_valid_out  out  1  output valid
- data_ready_in  in  1  downstream ready
- busy  out  1  high when the state is not IDLE
- done  out  1  one-cycle pulse after the last pixel is transferred
- cfg_err  out  1  one-cycle pulse on a rejected cfg_load
- ovf_flag  out  1  sticky accumulator overflow flag

Function
REQ-006 SHALL implement states IDLE, ACCUM, MUL, RND and OUT.
REQ-007 IDLE: cfg_load with cfg_acc_num>0 and cfg_pix_num>0 SHALL latch all cfg_* inputs, bias_in and scale_in, clear the beat and pixel counters, and enter ACCUM.
REQ-008 IDLE: cfg_load with either count equal to 0 SHALL pulse cfg_err for one cycle, and the state SHALL remain IDLE.
REQ-009 SHALL ignore cfg_load outside IDLE, with no latch and no cfg_err.
REQ-010 SHALL drive psum_ready_out high only in ACCUM.
REQ-011 First beat of a pixel: acc[c] SHALL be set to sext(bias[c]) + sext(psum[c]).
REQ-012 Subsequent beats: acc[c] SHALL be set to acc[c] + sext(psum[c]).
REQ-013 On acceptance of beat number cfg_acc_num, the state SHALL go to MUL; with cfg_acc_num=1 the first beat is also the last.
REQ-014 MUL SHALL register prod[c] = acc[c] * scale as a signed product of width ACC_WIDTH+SCALE_WIDTH+1, then go to RND.
REQ-015 RND SHALL compute r = (prod + 2^(cfg_shift-1)) >>> cfg_shift, with no rounding term when cfg_shift=0.
REQ-016 RND: if cfg_relu_en=1 and r<0, r SHALL be forced to 0.
REQ-017 RND SHALL saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], register it into data_out, and go to OUT.
REQ-018 Latency: data_valid_out SHALL be high in cycle N+3, where N is the cycle in which the last beat is accepted.
REQ-019 OUT SHALL hold data_valid_out and data_out stable until data_ready_in is high.
REQ-020 On transfer, the pixel counter SHALL increment; if it equals cfg_pix_num, the block SHALL pulse done and enter IDLE, otherwise it SHALL enter ACCUM.
REQ-021 SHALL drive busy = (state != IDLE).
REQ-022 SHALL leave data_out unchanged outside RND.

Reset
REQ-023 rst, including mid-operation, SHALL force state to IDLE on the next edge.
REQ-024 rst SHALL clear psum_ready_out, data_valid_out, busy, done, cfg_err, ovf_flag, data_out, all counters and all accumulators to 0.
REQ-025 SHALL discard any partial pixel on reset.

Configuration
REQ-026 With macro CONV_ACC_OVF_DETECT_EN defined, a signed overflow of any acc[c] add SHALL saturate that channel to the ACC_WIDTH maximum or minimum.
REQ-027 With CONV_ACC_OVF_DETECT_EN defined, such an overflow SHALL set ovf_flag, which stays set until rst or the next accepted cfg_load.
REQ-028 Without CONV_ACC_OVF_DETECT_EN, accumulation SHALL wrap modulo 2^ACC_WIDTH and ovf_flag SHALL be tied 0.

Verification
REQ-029 Basic path: acc_num=3, pix_num=1, bias=10, psums 5, 7, -2, scale=1, shift=0, relu=0, data_ready_in high -> data_out=20 in every channel, valid in cycle N+3, done pulses after transfer.
REQ-030 Rounding, saturation and ReLU: acc=300, scale=3, shift=2 -> 225 saturates to 127; acc=-6, shift=2, relu=1 -> 0; acc=6, shift=2 -> 2 (round half up of 1.5).
REQ-031 Backpressure: data_ready_in held low 5 cycles -> data_out stable, psum_ready_out low, and no beats consumed until transfer.
REQ-032 Config errors: cfg_load with acc_num=0 -> cfg_err one cycle, busy stays 0; cfg_load while busy -> ignored.
REQ-033 Reset during ACCUM after 2 of 4 beats -> IDLE, all outputs 0; a new run of 4 beats gives a result excluding the old beats.
REQ-034 CONV_ACC_OVF_DETECT_EN: ACC_WIDTH=24, sum exceeding 2^23-1 -> acc=8388607 and ovf_flag=1; with the macro undefined -> acc wraps and ovf_flag=0.

Source files
------------

// File: rtl/conv_accum_requant.sv
`default_nettype none
//==============================================================================
// Module   : conv_accum_requant
// Brief    : Per-channel convolution accumulator with requantisation.
//            Accumulates cfg_acc_num partial-sum beats per output pixel
//            (bias folded into the first beat), scales by a common unsigned
//            factor, rounds half-up on an arithmetic right shift, applies an
//            optional ReLU and saturates to a signed DATA_WIDTH result.
//            One result per pixel, cfg_pix_num pixels per run.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cfg_load/cfg_*      - run start pulse and run configuration
//            bias_in, scale_in   - per-channel bias, common scale (latched)
//            psum_in/valid/ready - partial-sum beat stream, channel 0 in LSBs
//            data_out/valid/ready- requantised pixel stream
//            busy, done, cfg_err - status; done and cfg_err are 1-cycle pulses
//            ovf_flag            - sticky accumulator overflow flag
// Options  : CONV_ACC_OVF_DETECT_EN - saturating accumulation with sticky
//            ovf_flag; when undefined accumulation wraps and ovf_flag is 0.
// Revision : 1.0 - initial release
//==============================================================================
module conv_accum_requant #(
    parameter int OUT_CH      = 18,
    parameter int PSUM_WIDTH  = 20,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 16,
    parameter int SCALE_WIDTH = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_load,
    input  logic [CNT_WIDTH-1:0]           cfg_acc_num,
    input  logic [CNT_WIDTH-1:0]           cfg_pix_num,
    input  logic [4:0]                     cfg_shift,
    input  logic                           cfg_relu_en,
    input  logic [OUT_CH*BIAS_WIDTH-1:0]   bias_in,
    input  logic [SCALE_WIDTH-1:0]         scale_in,
    input  logic [OUT_CH*PSUM_WIDTH-1:0]   psum_in,
    input  logic                           psum_valid_in,
    output logic                           psum_ready_out,
    output logic [OUT_CH*DATA_WIDTH-1:0]   data_out,
    output logic                           data_valid_out,
    input  logic                           data_ready_in,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err,
    output logic                           ovf_flag
);

    localparam int c_PROD_W = ACC_WIDTH + SCALE_WIDTH + 1;
    // One guard bit so the rounding add cannot overflow the product.
    localparam int c_RND_W  = c_PROD_W + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ACCUM = 3'd1;
    localparam logic [2:0] c_MUL   = 3'd2;
    localparam logic [2:0] c_RND   = 3'd3;
    localparam logic [2:0] c_OUT   = 3'd4;

    localparam logic signed [c_RND_W-1:0] c_DMAX = c_RND_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_RND_W-1:0] c_DMIN = -c_DMAX - c_RND_W'(1);
    localparam logic [DATA_WIDTH-1:0]     c_QMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]     c_QMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [2:0]                     r_state;
    logic [CNT_WIDTH-1:0]           r_acc_num;
    logic [CNT_WIDTH-1:0]           r_pix_num;
    logic [CNT_WIDTH-1:0]           r_beat_cnt;
    logic [CNT_WIDTH-1:0]           r_pix_cnt;
    logic [4:0]                     r_shift;
    logic                           r_relu_en;
    logic [OUT_CH*BIAS_WIDTH-1:0]   r_bias;
    logic [SCALE_WIDTH-1:0]         r_scale;
    logic signed [ACC_WIDTH-1:0]    r_acc  [OUT_CH];
    logic signed [c_PROD_W-1:0]     r_prod [OUT_CH];
    logic [OUT_CH*DATA_WIDTH-1:0]   r_data_out;
    logic                           r_done;
    logic                           r_cfg_err;

    logic                           w_beat_fire;
    logic                           w_first_beat;
    logic                           w_last_beat;
    logic                           w_xfer;
    logic                           w_last_pix;
    logic                           w_cfg_ok;
    logic signed [c_RND_W-1:0]      w_half;
    logic signed [ACC_WIDTH-1:0]    w_acc_next [OUT_CH];
    logic signed [c_PROD_W-1:0]     w_prod     [OUT_CH];
    logic [OUT_CH*DATA_WIDTH-1:0]   w_requant;

    assign w_beat_fire  = (r_state == c_ACCUM) && psum_valid_in;
    assign w_first_beat = (r_beat_cnt == '0);
    assign w_last_beat  = (r_beat_cnt == (r_acc_num - 1'b1));
    assign w_xfer       = (r_state == c_OUT) && data_ready_in;
    assign w_last_pix   = ((r_pix_cnt + 1'b1) == r_pix_num);
    assign w_cfg_ok     = (cfg_acc_num != '0) && (cfg_pix_num != '0);

    // Half-LSB of the shifted result; zero when no shift is applied.
    always_comb begin
        w_half = '0;
        if (r_shift != 5'd0) begin
            w_half = c_RND_W'(1) << (r_shift - 5'd1);
        end
    end

`ifdef CONV_ACC_OVF_DETECT_EN
    localparam int c_SUM_W = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] c_AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [OUT_CH-1:0] w_ovf;
    logic              r_ovf;

    generate
        for (genvar c = 0; c < OUT_CH; c++) begin : g_acc
            logic signed [c_SUM_W-1:0] w_base;
            logic signed [c_SUM_W-1:0] w_addend;
            logic signed [c_SUM_W-1:0] w_sum;

            assign w_base   = w_first_beat ? c_SUM_W'($signed(r_bias[c*BIAS_WIDTH +: BIAS_WIDTH]))
                                           : c_SUM_W'(r_acc[c]);
            assign w_addend = c_SUM_W'($signed(psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]));
            assign w_sum    = w_base + w_addend;
            // Top two bits disagree exactly when the sum left the ACC_WIDTH range.
            assign w_ovf[c] = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
            assign w_acc_next[c] = !w_ovf[c]          ? w_sum[ACC_WIDTH-1:0] :
                                   w_sum[ACC_WIDTH]   ? c_AMIN : c_AMAX;
        end
    endgenerate

    assign ovf_flag = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_IDLE) && cfg_load && w_cfg_ok) begin
            r_ovf <= 1'b0;
        end else if (w_beat_fire && (w_ovf != '0)) begin
            r_ovf <= 1'b1;
        end
    end
`else
    generate
        for (genvar c = 0; c < OUT_CH; c++) begin : g_acc
            logic signed [ACC_WIDTH-1:0] w_base;

            assign w_base = w_first_beat ? ACC_WIDTH'($signed(r_bias[c*BIAS_WIDTH +: BIAS_WIDTH]))
                                         : r_acc[c];
            // Plain ACC_WIDTH add: wraps modulo 2^ACC_WIDTH.
            assign w_acc_next[c] = w_base + ACC_WIDTH'($signed(psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]));
        end
    endgenerate

    assign ovf_flag = 1'b0;
`endif

    generate
        for (genvar c = 0; c < OUT_CH; c++) begin : g_rq
            logic signed [c_RND_W-1:0] w_rnd;
            logic signed [c_RND_W-1:0] w_shr;

            // Scale is unsigned: the zero MSB keeps it positive in the signed multiply.
            assign w_prod[c] = c_PROD_W'(r_acc[c]) * c_PROD_W'($signed({1'b0, r_scale}));
            assign w_rnd     = c_RND_W'(r_prod[c]) + w_half;
            assign w_shr     = w_rnd >>> r_shift;
            assign w_requant[c*DATA_WIDTH +: DATA_WIDTH] =
                (r_relu_en && (w_shr < 0)) ? '0     :
                (w_shr > c_DMAX)           ? c_QMAX :
                (w_shr < c_DMIN)           ? c_QMIN :
                                             w_shr[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_acc_num  <= '0;
            r_pix_num  <= '0;
            r_beat_cnt <= '0;
            r_pix_cnt  <= '0;
            r_shift    <= '0;
            r_relu_en  <= 1'b0;
            r_bias     <= '0;
            r_scale    <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            for (int c = 0; c < OUT_CH; c++) begin
                r_acc[c]  <= '0;
                r_prod[c] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cfg_load) begin
                        if (w_cfg_ok) begin
                            r_acc_num  <= cfg_acc_num;
                            r_pix_num  <= cfg_pix_num;
                            r_shift    <= cfg_shift;
                            r_relu_en  <= cfg_relu_en;
                            r_bias     <= bias_in;
                            r_scale    <= scale_in;
                            r_beat_cnt <= '0;
                            r_pix_cnt  <= '0;
                            r_state    <= c_ACCUM;
                        end else begin
                            r_cfg_err  <= 1'b1;
                        end
                    end
                end
                c_ACCUM: begin
                    if (w_beat_fire) begin
                        for (int c = 0; c < OUT_CH; c++) begin
                            r_acc[c] <= w_acc_next[c];
                        end
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_state    <= c_MUL;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                c_MUL: begin
                    for (int c = 0; c < OUT_CH; c++) begin
                        r_prod[c] <= w_prod[c];
                    end
                    r_state <= c_RND;
                end
                c_RND: begin
                    r_data_out <= w_requant;
                    r_state    <= c_OUT;
                end
                c_OUT: begin
                    if (w_xfer) begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                        if (w_last_pix) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_ACCUM;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign psum_ready_out = (r_state == c_ACCUM);
    assign data_valid_out = (r_state == c_OUT);
    assign busy           = (r_state != c_IDLE);
    assign data_out       = r_data_out;
    assign done           = r_done;
    assign cfg_err        = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_accum_requant.sv
`default_nettype none
//==============================================================================
// Module   : tb_conv_accum_requant
// Brief    : Self-checking bench for conv_accum_requant. Directed cases for
//            the basic path, rounding/saturation/ReLU, backpressure, config
//            errors, mid-run reset and accumulator overflow, followed by
//            randomised runs checked against an arithmetic reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_conv_accum_requant;

    localparam int OUT_CH = 4;
    localparam int PW     = 20;
    localparam int AW     = 24;
    localparam int BW     = 16;
    localparam int SW     = 16;
    localparam int DW     = 8;
    localparam int CW     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_load;
    logic [CW-1:0]        cfg_acc_num;
    logic [CW-1:0]        cfg_pix_num;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu_en;
    logic [OUT_CH*BW-1:0] bias_in;
    logic [SW-1:0]        scale_in;
    logic [OUT_CH*PW-1:0] psum_in;
    logic                 psum_valid_in;
    logic                 psum_ready_out;
    logic [OUT_CH*DW-1:0] data_out;
    logic                 data_valid_out;
    logic                 data_ready_in;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic                 ovf_flag;

    always #5 clk = ~clk;

    conv_accum_requant #(
        .OUT_CH(OUT_CH), .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
        .SCALE_WIDTH(SW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_acc_num(cfg_acc_num),
        .cfg_pix_num(cfg_pix_num), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .bias_in(bias_in), .scale_in(scale_in), .psum_in(psum_in),
        .psum_valid_in(psum_valid_in), .psum_ready_out(psum_ready_out),
        .data_out(data_out), .data_valid_out(data_valid_out),
        .data_ready_in(data_ready_in), .busy(busy), .done(done),
        .cfg_err(cfg_err), .ovf_flag(ovf_flag)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference stimulus: bias per channel, psum[pixel][beat][channel].
    int m_bias [OUT_CH];
    int m_psum [4][24][OUT_CH];
    bit m_ovf;

    function automatic int rnd_s(input int w);
        logic [31:0] u;
        u = $urandom;
        return $signed(u << (32 - w)) >>> (32 - w);
    endfunction

    // Bring an exact sum back into the accumulator's range.
    function automatic longint acc_fix(input longint a);
        logic [AW-1:0] t;
`ifdef CONV_ACC_OVF_DETECT_EN
        longint amax;
        amax = (longint'(1) <<< (AW - 1)) - 1;
        if (a > amax) begin m_ovf = 1'b1; return amax; end
        if (a < -amax - 1) begin m_ovf = 1'b1; return -amax - 1; end
        return a;
`else
        t = a[AW-1:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic logic [OUT_CH*DW-1:0] model_pixel(input int p, input int acc_n,
                                                         input int shift, input bit relu,
                                                         input int scale);
        logic [OUT_CH*DW-1:0] res;
        logic [63:0]          rb;
        longint               a, r, qmax;
        qmax = (longint'(1) <<< (DW - 1)) - 1;
        res  = '0;
        for (int c = 0; c < OUT_CH; c++) begin
            a = acc_fix(longint'(m_bias[c]) + longint'(m_psum[p][0][c]));
            for (int b = 1; b < acc_n; b++) a = acc_fix(a + longint'(m_psum[p][b][c]));
            r = a * longint'(scale);
            if (shift > 0) r = r + (longint'(1) <<< (shift - 1));
            r = r >>> shift;
            if (relu && r < 0) r = 0;
            if (r > qmax) r = qmax;
            if (r < -qmax - 1) r = -qmax - 1;
            rb = r;
            res[c*DW +: DW] = rb[DW-1:0];
        end
        return res;
    endfunction

    function automatic logic [OUT_CH*PW-1:0] junk_psum();
        logic [OUT_CH*PW-1:0] v;
        logic [31:0]          t;
        for (int c = 0; c < OUT_CH; c++) begin
            t = rnd_s(PW);
            v[c*PW +: PW] = t[PW-1:0];
        end
        return v;
    endfunction

    task automatic fill_rand(input int pix, input int acc);
        for (int c = 0; c < OUT_CH; c++) m_bias[c] = rnd_s(BW);
        for (int p = 0; p < pix; p++)
            for (int b = 0; b < acc; b++)
                for (int c = 0; c < OUT_CH; c++) m_psum[p][b][c] = rnd_s(PW);
    endtask

    // All sequencing tasks start and end at a falling edge.
    task automatic do_load(input int acc, input int pix, input int shift, input bit relu,
                           input int scale);
        logic [31:0] t;
        logic [31:0] s;
        @(negedge clk);
        cfg_acc_num = CW'(acc);
        cfg_pix_num = CW'(pix);
        cfg_shift   = 5'(shift);
        cfg_relu_en = relu;
        s           = scale;
        scale_in    = s[SW-1:0];
        for (int c = 0; c < OUT_CH; c++) begin
            t = m_bias[c];
            bias_in[c*BW +: BW] = t[BW-1:0];
        end
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        // Scramble the config inputs so only latched values can be used.
        cfg_acc_num = CW'($urandom);
        cfg_pix_num = CW'($urandom);
        cfg_shift   = 5'($urandom);
        cfg_relu_en = 1'($urandom);
        scale_in    = SW'($urandom);
        bias_in     = {$urandom, $urandom};
        m_ovf       = 1'b0;
    endtask

    task automatic send_beat(input int p, input int b, input int gapmax);
        int          g, t;
        logic [31:0] v;
        g = $urandom_range(0, gapmax);
        repeat (g) begin
            psum_valid_in = 1'b0;
            @(negedge clk);
        end
        for (int c = 0; c < OUT_CH; c++) begin
            v = m_psum[p][b][c];
            psum_in[c*PW +: PW] = v[PW-1:0];
        end
        psum_valid_in = 1'b1;
        t = 0;
        while (!psum_ready_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("beat accept timeout", 64'(t), 0);
        @(posedge clk);
        @(negedge clk);
        psum_valid_in = 1'b0;
    endtask

    task automatic run_body(input int acc, input int pix, input int shift, input bit relu,
                            input int scale, input bit rdy_always, input int hold_force,
                            input int gapmax, input string tag);
        logic [OUT_CH*DW-1:0] exp, snap;
        int                   k, hold;
        bit                   stable;
        check({tag, " busy after load"}, 64'(busy), 1);
        data_ready_in = rdy_always;
        for (int p = 0; p < pix; p++) begin
            for (int b = 0; b < acc; b++) send_beat(p, b, gapmax);
            // Junk beats offered while not in ACCUM must never be consumed.
            psum_valid_in = 1'b1;
            psum_in       = junk_psum();
            k = 1;
            while (!data_valid_out && k < 20) begin
                @(negedge clk);
                k++;
            end
            check({tag, " latency"}, 64'(k), 3);
            exp = model_pixel(p, acc, shift, relu, scale);
            check({tag, " data_out"}, 64'(data_out), 64'(exp));
            hold = (hold_force >= 0) ? hold_force : $urandom_range(0, 5);
            if (!rdy_always && hold > 0) begin
                stable = 1'b1;
                snap   = data_out;
                for (int h = 0; h < hold; h++) begin
                    psum_in = junk_psum();
                    @(negedge clk);
                    if (data_out !== snap || !data_valid_out || psum_ready_out) stable = 1'b0;
                end
                check({tag, " stall hold"}, 64'(stable), 1);
            end
            data_ready_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            data_ready_in = rdy_always;
            psum_valid_in = 1'b0;
            check({tag, " done pulse"}, 64'(done), 64'(p == pix - 1));
            if (p == pix - 1) begin
                check({tag, " idle after run"}, 64'(busy), 0);
                @(negedge clk);
                check({tag, " done one cycle"}, 64'(done), 0);
            end
        end
        check({tag, " ovf_flag"}, 64'(ovf_flag), 64'(m_ovf));
        data_ready_in = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, pix, shift, scale;
        bit relu;

        rst = 1'b1; cfg_load = 1'b0; cfg_acc_num = '0; cfg_pix_num = '0;
        cfg_shift = '0; cfg_relu_en = 1'b0; bias_in = '0; scale_in = '0;
        psum_in = '0; psum_valid_in = 1'b0; data_ready_in = 1'b0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset status", 64'({busy, psum_ready_out, data_valid_out, done, cfg_err, ovf_flag}), 0);
        check("reset data_out", 64'(data_out), 0);

        // Basic path: bias 10, beats 5, 7, -2 -> 20 everywhere.
        for (int c = 0; c < OUT_CH; c++) begin
            m_bias[c] = 10; m_psum[0][0][c] = 5; m_psum[0][1][c] = 7; m_psum[0][2][c] = -2;
        end
        do_load(3, 1, 0, 1'b0, 1);
        run_body(3, 1, 0, 1'b0, 1, 1'b1, 0, 0, "basic");
        check("basic result held", 64'(data_out), 64'(32'h14141414));

        // Rounding and saturation: 300*3>>2 -> 127, -300*3 -> -128, 6*3 -> 5, -6*3 -> -4.
        for (int c = 0; c < OUT_CH; c++) m_bias[c] = 0;
        m_psum[0][0][0] = 300; m_psum[0][0][1] = -300; m_psum[0][0][2] = 6; m_psum[0][0][3] = -6;
        do_load(1, 1, 2, 1'b0, 3);
        run_body(1, 1, 2, 1'b0, 3, 1'b0, 1, 1, "round sat");
        check("round sat const", 64'(data_out), 64'(32'hFC05807F));

        // ReLU and round half up: 6>>2 -> 2, -6 -> 0, 300>>2 -> 75, -300 -> 0.
        m_psum[0][0][0] = 6; m_psum[0][0][1] = -6; m_psum[0][0][2] = 300; m_psum[0][0][3] = -300;
        do_load(1, 1, 2, 1'b1, 1);
        run_body(1, 1, 2, 1'b1, 1, 1'b0, 0, 0, "relu");
        check("relu const", 64'(data_out), 64'(32'h004B0002));

        // Backpressure: 5-cycle stall on each of two pixels.
        fill_rand(2, 3);
        do_load(3, 2, 4, 1'b0, 200);
        run_body(3, 2, 4, 1'b0, 200, 1'b0, 5, 1, "backpressure");

        // Config errors in IDLE.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cfg_acc_num = (i == 0) ? CW'(0) : CW'(3);
            cfg_pix_num = (i == 0) ? CW'(2) : CW'(0);
            cfg_load = 1'b1;
            @(negedge clk);
            cfg_load = 1'b0;
            check("cfg_err pulse", 64'({cfg_err, busy}), 64'(2'b10));
            @(negedge clk);
            check("cfg_err one cycle", 64'({cfg_err, busy}), 0);
        end

        // cfg_load while busy is ignored.
        fill_rand(1, 2);
        do_load(2, 1, 3, 1'b0, 77);
        cfg_acc_num = '0; cfg_pix_num = CW'(1); cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        check("busy load no err", 64'({cfg_err, busy}), 64'(2'b01));
        cfg_acc_num = CW'(1); cfg_pix_num = CW'(1); scale_in = SW'(5); cfg_shift = 5'd0;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        run_body(2, 1, 3, 1'b0, 77, 1'b0, -1, 1, "busy load");

        // Reset after 2 of 4 beats, then a clean 4-beat run.
        fill_rand(1, 4);
        do_load(4, 1, 1, 1'b0, 9);
        send_beat(0, 0, 0);
        send_beat(0, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset status", 64'({busy, psum_ready_out, data_valid_out, done, cfg_err, ovf_flag}), 0);
        check("mid reset data_out", 64'(data_out), 0);
        fill_rand(1, 4);
        do_load(4, 1, 1, 1'b0, 9);
        run_body(4, 1, 1, 1'b0, 9, 1'b0, -1, 1, "after reset");

        // Accumulator overflow: 20 beats of +/- full-scale psums exceed 24 bits.
        for (int c = 0; c < OUT_CH; c++) m_bias[c] = 0;
        for (int b = 0; b < 20; b++) begin
            m_psum[0][b][0] = (1 << (PW - 1)) - 1;
            m_psum[0][b][1] = (1 << (PW - 1)) - 1;
            m_psum[0][b][2] = -(1 << (PW - 1));
            m_psum[0][b][3] = rnd_s(8);
        end
        do_load(20, 1, 17, 1'b0, 1);
        run_body(20, 1, 17, 1'b0, 1, 1'b1, 0, 0, "overflow");
        fill_rand(1, 2);
        do_load(2, 1, 0, 1'b0, 1);
        check("ovf cleared by load", 64'(ovf_flag), 0);
        run_body(2, 1, 0, 1'b0, 1, 1'b0, -1, 0, "post ovf");

        // Randomised runs.
        for (int r = 0; r < 8; r++) begin
            acc   = $urandom_range(1, 5);
            pix   = $urandom_range(1, 3);
            shift = $urandom_range(0, 31);
            relu  = 1'($urandom);
            scale = $urandom_range(0, 65535);
            fill_rand(pix, acc);
            do_load(acc, pix, shift, relu, scale);
            run_body(acc, pix, shift, relu, scale, 1'($urandom), -1, 2, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
